coherence_arbiter: RTL and testbench

Shared-memory controller for the dual-core build. It sits between two coherent L1 dcaches, two icaches and the single-ported RAM. It arbitrates RAM access among the four caches and sequences MSI-style snoop transactions between the dcaches. On a snoop hit-dirty it performs cache-to-cache forwarding, writing the same data back to RAM at the same time.

---
 rtl/coherence_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_coherence_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_arbiter.sv
// coherence_arbiter
//   Shared-memory controller for the dual-core build. It arbitrates the single
//   RAM port among two dcaches and two icaches. It also runs MSI snoops between
//   the dcaches. When a snoop hits a dirty line, the snooper's data is forwarded
//   to the requester and written back to RAM in the same cycle.
//
// Ports (index c in {0,1}):
//   CLK, RST            clock, synchronous active-high reset
//   iREN/iaddr          icache read request and word address
//   iwait/iload         icache handshake (low one cycle per word) and data
//   dREN/dWEN           dcache read / write request
//   daddr/dstore        dcache word address and write data
//   cctrans/ccwrite     coherence request (or snoop response) / modify-or-dirty
//   dwait/dload         dcache handshake (low one cycle per word) and data
//   ccwait/ccinv        snoop request and invalidate to cache c
//   ccsnoopaddr         snoop address to cache c
//   ramREN/ramWEN       RAM strobes
//   ramaddr/ramstore    RAM address and write data
//   ramload/ram_ready   RAM read data and completion
module coherence_arbiter #(
    parameter int CPUS = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CPUS-1:0]           iREN,
    input  logic [CPUS-1:0][31:0]     iaddr,
    output logic [CPUS-1:0]           iwait,
    output logic [CPUS-1:0][31:0]     iload,
    input  logic [CPUS-1:0]           dREN,
    input  logic [CPUS-1:0]           dWEN,
    input  logic [CPUS-1:0][31:0]     daddr,
    input  logic [CPUS-1:0][31:0]     dstore,
    input  logic [CPUS-1:0]           cctrans,
    input  logic [CPUS-1:0]           ccwrite,
    output logic [CPUS-1:0]           dwait,
    output logic [CPUS-1:0][31:0]     dload,
    output logic [CPUS-1:0]           ccwait,
    output logic [CPUS-1:0]           ccinv,
    output logic [CPUS-1:0][31:0]     ccsnoopaddr,
    output logic                      ramREN,
    output logic                      ramWEN,
    output logic [31:0]               ramaddr,
    output logic [31:0]               ramstore,
    input  logic [31:0]               ramload,
    input  logic                      ram_ready
);

    typedef enum logic [2:0] {
        IDLE, DWRITE, SNOOP, FWD1, FWD2, RD1, RD2, IFETCH
    } state_t;

    state_t          state, state_n;
    logic            req, req_n;
    logic            snp;
    logic [31:0]     saddr, saddr_n;
    logic            sinv, sinv_n;
    logic            rr, rr_n;
    logic            ipri, ipri_n;
    logic [CPUS-1:0] pend_upg;
    logic [CPUS-1:0] upg_set;
    logic [CPUS-1:0] upg_clr;
    logic [CPUS-1:0] resp_mask;
    logic [CPUS-1:0] wr_req;
    logic [CPUS-1:0] snp_req;
    logic            gw, gs, gi;

    // Round-robin pick: on a tie the cache not granted last time wins.
    function automatic logic pick(input logic [1:0] v, input logic last);
        if (&v)
            return ~last;
        else
            return v[1];
    endfunction

    assign snp     = ~req;
    assign wr_req  = dWEN & ~cctrans;
    assign snp_req = (cctrans & dREN) | pend_upg;
    assign gw      = pick(wr_req, rr);
    assign gs      = pick(snp_req, rr);
    assign gi      = pick(iREN, ipri);

    // The snooper's cctrans is a response, not an upgrade pulse. Mask it
    // while a snoop is outstanding or forwarding.
    always_comb begin
        resp_mask = '0;
        if (state == SNOOP || state == FWD1 || state == FWD2)
            resp_mask[snp] = 1'b1;
    end

    assign upg_set = cctrans & ~dREN & ~dWEN & ~resp_mask;

    always_comb begin
        state_n     = state;
        req_n       = req;
        saddr_n     = saddr;
        sinv_n      = sinv;
        rr_n        = rr;
        ipri_n      = ipri;
        upg_clr     = '0;
        iwait       = '1;
        iload       = '0;
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (state)
            IDLE: begin
                // Writebacks outrank snoops, so a snoop target that is
                // mid-eviction can always drain first.
                if (|wr_req) begin
                    state_n = DWRITE;
                    req_n   = gw;
                    rr_n    = gw;
                end else if (|snp_req) begin
                    state_n     = SNOOP;
                    req_n       = gs;
                    rr_n        = gs;
                    saddr_n     = daddr[gs];
                    sinv_n      = ccwrite[gs] | pend_upg[gs];
                    upg_clr[gs] = pend_upg[gs];
                end else if (|iREN) begin
                    state_n = IFETCH;
                    req_n   = gi;
                    ipri_n  = gi;
                end
            end

            DWRITE: begin
                if (!dWEN[req]) begin
                    state_n = IDLE;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[req];
                    ramstore = dstore[req];
                    if (ram_ready) begin
                        dwait[req] = 1'b0;
                        state_n    = IDLE;
                    end
                end
            end

            SNOOP: begin
                ccwait[snp]      = 1'b1;
                ccsnoopaddr[snp] = saddr;
                ccinv[snp]       = sinv;
                if (cctrans[snp]) begin
                    if (ccwrite[snp])
                        state_n = FWD1;
                    else if (dREN[req])
                        state_n = RD1;
                    else
                        state_n = IDLE;
                end
            end

            FWD1, FWD2: begin
                // Dirty line: the snooper's write-back data feeds RAM and
                // the requester in the same cycle.
                ramWEN   = 1'b1;
                ramaddr  = daddr[snp];
                ramstore = dstore[snp];
                if (dREN[req])
                    dload[req] = dstore[snp];
                if (ram_ready) begin
                    dwait[snp] = 1'b0;
                    if (dREN[req])
                        dwait[req] = 1'b0;
                    state_n = (state == FWD1) ? FWD2 : IDLE;
                end
            end

            RD1, RD2: begin
                if (!dREN[req]) begin
                    state_n = IDLE;
                end else begin
                    ramREN     = 1'b1;
                    ramaddr    = daddr[req];
                    dload[req] = ramload;
                    if (ram_ready) begin
                        dwait[req] = 1'b0;
                        state_n    = (state == RD1) ? RD2 : IDLE;
                    end
                end
            end

            IFETCH: begin
                if (!iREN[req]) begin
                    state_n = IDLE;
                end else begin
                    ramREN     = 1'b1;
                    ramaddr    = iaddr[req];
                    iload[req] = ramload;
                    if (ram_ready) begin
                        iwait[req] = 1'b0;
                        state_n    = IDLE;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            req      <= 1'b0;
            saddr    <= '0;
            sinv     <= 1'b0;
            rr       <= 1'b0;
            ipri     <= 1'b0;
            pend_upg <= '0;
        end else begin
            state    <= state_n;
            req      <= req_n;
            saddr    <= saddr_n;
            sinv     <= sinv_n;
            rr       <= rr_n;
            ipri     <= ipri_n;
            // A new pulse in the same cycle as the grant keeps the flag set.
            pend_upg <= (pend_upg & ~upg_clr) | upg_set;
        end
    end

endmodule

// File: tb/tb_coherence_arbiter.sv
// tb_coherence_arbiter
//   Directed stimulus for coherence_arbiter. Each completed word is checked
//   by a scoreboard. The stimulus side pushes expected responses, and a
//   negedge monitor pops one entry whenever any dwait/iwait goes low.
module tb_coherence_arbiter;

    logic              CLK = 1'b0;
    logic              RST;
    logic [1:0]        iREN;
    logic [1:0][31:0]  iaddr;
    logic [1:0]        iwait;
    logic [1:0][31:0]  iload;
    logic [1:0]        dREN;
    logic [1:0]        dWEN;
    logic [1:0][31:0]  daddr;
    logic [1:0][31:0]  dstore;
    logic [1:0]        cctrans;
    logic [1:0]        ccwrite;
    logic [1:0]        dwait;
    logic [1:0][31:0]  dload;
    logic [1:0]        ccwait;
    logic [1:0]        ccinv;
    logic [1:0][31:0]  ccsnoopaddr;
    logic              ramREN;
    logic              ramWEN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramstore;
    logic [31:0]       ramload;
    logic              ram_ready;

    typedef struct packed {
        logic [1:0]  dw;
        logic [1:0]  iw;
        logic [31:0] dl0;
        logic [31:0] dl1;
        logic [31:0] il0;
        logic [31:0] il1;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
    } resp_t;

    resp_t q[$];
    resp_t mon_act;
    resp_t mon_exp;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    coherence_arbiter #(.CPUS(2)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .dwait(dwait), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    // RAM contents: two fixed words, everything else derived from the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h100)      return 32'h0000AAAA;
        else if (a == 32'h104) return 32'h0000BBBB;
        else                   return {a[15:0], ~a[15:0]};
    endfunction

    always_comb ramload = memf(ramaddr);

    function automatic resp_t mk(input logic [1:0] dw, input logic [1:0] iw,
                                 input logic [31:0] dl0, input logic [31:0] dl1,
                                 input logic [31:0] il0, input logic [31:0] il1,
                                 input logic ren, input logic wen,
                                 input logic [31:0] a, input logic [31:0] s);
        return {dw, iw, dl0, dl1, il0, il1, ren, wen, a, s};
    endfunction

    always @(negedge CLK) begin
        if (mon_en && !RST && (dwait != 2'b11 || iwait != 2'b11)) begin
            mon_act = {dwait, iwait, dload[0], dload[1], iload[0], iload[1],
                       ramREN, ramWEN, ramaddr, ramstore};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected act=%h exp=none", mon_act);
            end else begin
                mon_exp = q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL word act=%h exp=%h", mon_act, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
        cctrans = '0; ccwrite = '0;
    endtask

    // Wait for a snoop request to cache c; returns at the negedge it is seen.
    task automatic wait_cc(input int c);
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (ccwait[c]) break;
        end
        chk($sformatf("ccwait%0d_seen", c), {31'b0, ccwait[c]}, 32'h1);
    endtask

    // Wait for dwait[c] low; returns 1 time unit after the following posedge.
    task automatic wait_dw(input int c);
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (!dwait[c]) break;
        end
        chk($sformatf("dwait%0d_seen", c), {31'b0, dwait[c]}, 32'h0);
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

    initial begin
        // Reset with every request asserted.
        RST = 1'b1; ram_ready = 1'b1;
        clear_inputs();
        iREN = '1; dREN = '1; dWEN = '1; cctrans = '1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_dwait", {30'b0, dwait}, 32'h3);
        chk("rst_iwait", {30'b0, iwait}, 32'h3);
        chk("rst_strobes", {30'b0, ramREN, ramWEN}, 32'h0);
        chk("rst_ccwait", {30'b0, ccwait}, 32'h0);
        chk("rst_ccinv", {30'b0, ccinv}, 32'h0);
        chk("rst_snpaddr0", ccsnoopaddr[0], 32'h0);
        chk("rst_snpaddr1", ccsnoopaddr[1], 32'h0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0; clear_inputs(); mon_en = 1'b1;
        @(posedge CLK); #1;

        // Cache 0 read miss, clean snoop by cache 1.
        dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h100;
        q.push_back(mk(2'b10, 2'b11, 32'h0000AAAA, 0, 0, 0, 1'b1, 1'b0, 32'h100, 0));
        q.push_back(mk(2'b10, 2'b11, 32'h0000BBBB, 0, 0, 0, 1'b1, 1'b0, 32'h104, 0));
        wait_cc(1);
        chk("rm_ccinv1", {31'b0, ccinv[1]}, 32'h0);
        chk("rm_snpaddr1", ccsnoopaddr[1], 32'h100);
        chk("rm_ccwait0", {31'b0, ccwait[0]}, 32'h0);
        cctrans[1] = 1'b1; ccwrite[1] = 1'b0;
        @(posedge CLK); #1;
        cctrans[1] = 1'b0; cctrans[0] = 1'b0;
        @(negedge CLK);
        chk("rm_ccwait_1cyc", {30'b0, ccwait}, 32'h0);
        @(posedge CLK); #1;
        daddr[0] = 32'h104;
        wait_dw(0);
        clear_inputs();
        @(posedge CLK); #1;

        // Cache 1 write miss, dirty in cache 0: forward plus write-back.
        dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h200;
        q.push_back(mk(2'b00, 2'b11, 0, 32'h11, 0, 0, 1'b0, 1'b1, 32'h200, 32'h11));
        q.push_back(mk(2'b00, 2'b11, 0, 32'h22, 0, 0, 1'b0, 1'b1, 32'h204, 32'h22));
        wait_cc(0);
        chk("wm_ccinv0", {31'b0, ccinv[0]}, 32'h1);
        chk("wm_snpaddr0", ccsnoopaddr[0], 32'h200);
        cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h200; dstore[0] = 32'h11;
        wait_dw(1);
        dstore[0] = 32'h22; daddr[0] = 32'h204;
        wait_dw(1);
        clear_inputs();
        @(posedge CLK); #1;

        // Tie between two read misses with rr=0: cache 1 first, then cache 0.
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        dREN = 2'b11; cctrans = 2'b11; daddr[0] = 32'h300; daddr[1] = 32'h400;
        q.push_back(mk(2'b01, 2'b11, 0, 32'h0400FBFF, 0, 0, 1'b1, 1'b0, 32'h400, 0));
        q.push_back(mk(2'b01, 2'b11, 0, 32'h0400FBFF, 0, 0, 1'b1, 1'b0, 32'h400, 0));
        q.push_back(mk(2'b10, 2'b11, 32'h0300FCFF, 0, 0, 0, 1'b1, 1'b0, 32'h300, 0));
        q.push_back(mk(2'b10, 2'b11, 32'h0300FCFF, 0, 0, 0, 1'b1, 1'b0, 32'h300, 0));
        wait_cc(0);
        wait_dw(0);
        wait_dw(0);
        clear_inputs();
        @(posedge CLK); #1;

        // Upgrade pulse during a stalled ifetch, then invalidate-only snoop.
        iREN[0] = 1'b1; iaddr[0] = 32'h40; daddr[0] = 32'h500; ram_ready = 1'b0;
        @(posedge CLK); #1;
        cctrans[0] = 1'b1;
        @(negedge CLK);
        chk("up_ifetch_ren", {31'b0, ramREN}, 32'h1);
        chk("up_ifetch_addr", ramaddr, 32'h40);
        chk("up_iwait_stall", {30'b0, iwait}, 32'h3);
        @(posedge CLK); #1;
        cctrans[0] = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        q.push_back(mk(2'b11, 2'b10, 0, 0, 32'h0040FFBF, 0, 1'b1, 1'b0, 32'h40, 0));
        ram_ready = 1'b1;
        @(posedge CLK); #1;
        iREN[0] = 1'b0;
        wait_cc(1);
        chk("up_ccinv1", {31'b0, ccinv[1]}, 32'h1);
        chk("up_snpaddr1", ccsnoopaddr[1], 32'h500);
        chk("up_snoop_noram", {30'b0, ramREN, ramWEN}, 32'h0);
        cctrans[1] = 1'b1;
        @(posedge CLK); #1;
        cctrans[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("up_after_noram", {30'b0, ramREN, ramWEN}, 32'h0);
            chk("up_after_ccwait", {30'b0, ccwait}, 32'h0);
        end
        @(posedge CLK); #1;

        // Eviction from cache 1 outranks cache 0's miss snoop.
        dWEN[1] = 1'b1; daddr[1] = 32'h600; dstore[1] = 32'hDEAD;
        dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h700;
        q.push_back(mk(2'b01, 2'b11, 0, 0, 0, 0, 1'b0, 1'b1, 32'h600, 32'hDEAD));
        q.push_back(mk(2'b10, 2'b11, 32'h0700F8FF, 0, 0, 0, 1'b1, 1'b0, 32'h700, 0));
        q.push_back(mk(2'b10, 2'b11, 32'h0700F8FF, 0, 0, 0, 1'b1, 1'b0, 32'h700, 0));
        @(negedge CLK);
        @(negedge CLK);
        chk("wb_first_ccwait", {30'b0, ccwait}, 32'h0);
        chk("wb_first_wen", {31'b0, ramWEN}, 32'h1);
        @(posedge CLK); #1;
        dWEN[1] = 1'b0;
        wait_cc(1);
        cctrans[1] = 1'b1;
        @(posedge CLK); #1;
        cctrans[1] = 1'b0;
        wait_dw(0);
        wait_dw(0);
        clear_inputs();
        @(posedge CLK); #1;

        // Reset in the middle of an ifetch abandons it.
        iREN[1] = 1'b1; iaddr[1] = 32'h80; ram_ready = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("mr_ifetch_ren", {31'b0, ramREN}, 32'h1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; iREN = '0; ram_ready = 1'b1;
        @(negedge CLK);
        chk("mr_strobes", {30'b0, ramREN, ramWEN}, 32'h0);
        chk("mr_iwait", {30'b0, iwait}, 32'h3);
        @(posedge CLK); #1;

        chk("sb_drained", q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
